// File: rtl/sd_otf_conv_pkg.sv
// -----------------------------------------------------------------------------
// sd_otf_conv_pkg
// Shared definitions for the signed-digit multiplier datapath: borrow-save
// digit encodings and the on-the-fly converter FSM state encoding.
// -----------------------------------------------------------------------------
package sd_otf_conv_pkg;

    // Borrow-save digit codes. Both 2'b00 and 2'b11 mean zero.
    localparam logic [1:0] DIGIT_PLUS     = 2'b10;
    localparam logic [1:0] DIGIT_MINUS    = 2'b01;
    localparam logic [1:0] DIGIT_ZERO     = 2'b00;
    localparam logic [1:0] DIGIT_ZERO_ALT = 2'b11;

    // ACC: accepting digits of the current word.
    // OUT: result held on out_data until the consumer takes it.
    typedef enum logic {
        ST_ACC = 1'b0,
        ST_OUT = 1'b1
    } otf_state_t;

endpackage

// File: rtl/sd_digit_decode.sv
// -----------------------------------------------------------------------------
// sd_digit_decode
// Maps one borrow-save digit onto a pair of one-hot flags; both flags low
// means a zero digit.
// Ports:
//   in_digit  in  2  borrow-save digit code
//   is_pos    out 1  digit is +1
//   is_neg    out 1  digit is -1
// -----------------------------------------------------------------------------
module sd_digit_decode
    import sd_otf_conv_pkg::*;
(
    input  logic [1:0] in_digit,
    output logic       is_pos,
    output logic       is_neg
);

    always_comb begin
        // NOTE: default every output before the case so no path leaves one unassigned (no latch).
        is_pos = 1'b0;
        is_neg = 1'b0;
        case (in_digit)
            DIGIT_PLUS:                 is_pos = 1'b1;
            DIGIT_MINUS:                is_neg = 1'b1;
            DIGIT_ZERO, DIGIT_ZERO_ALT: begin end
            default:                    begin end
        endcase
    end

endmodule

// File: rtl/sd_otf_conv.sv
// -----------------------------------------------------------------------------
// sd_otf_conv
// On-the-fly conversion of an ND-digit MSB-first signed-digit stream into an
// (ND+1)-bit two's-complement word. Two candidate registers are kept: Q (the
// value so far) and QM (Q minus one ulp). Each digit only shifts and appends a
// bit, so there is never a carry-propagate adder in the digit path.
// Ports:
//   clk        in   1     rising-edge clock
//   rst        in   1     synchronous active-high reset
//   in_valid   in   1     in_digit valid this cycle
//   in_ready   out  1     converter accepts a digit this cycle
//   in_digit   in   2     borrow-save digit (10=+1, 01=-1, 00/11=0)
//   out_valid  out  1     out_data holds a completed conversion
//   out_ready  in   1     downstream takes out_data this cycle
//   out_data   out  ND+1  two's-complement result
// -----------------------------------------------------------------------------
module sd_otf_conv
    import sd_otf_conv_pkg::*;
#(
    parameter int ND = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [1:0]    in_digit,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [ND:0]   out_data
);

    localparam int            CW   = (ND > 1) ? $clog2(ND) : 1;
    localparam logic [CW-1:0] LAST = CW'(ND - 1);

    otf_state_t    state;
    logic [ND:0]   q;
    logic [ND:0]   qm;
    logic [ND:0]   q_next;
    logic [ND:0]   qm_next;
    logic [CW-1:0] cnt;
    logic          is_pos;
    logic          is_neg;
    logic          accept;

    sd_digit_decode u_decode (
        .in_digit (in_digit),
        .is_pos   (is_pos),
        .is_neg   (is_neg)
    );

    // in_ready is the only combinational output; it is forced low during reset.
    assign in_ready = (state == ST_ACC) && !rst;
    assign accept   = in_valid && in_ready;

    // Shift-and-append selection. A -1 digit borrows from the prefix, so the
    // new Q comes from QM; a +1 digit makes the old Q the new QM prefix.
    always_comb begin
        q_next  = {q[ND-1:0],  1'b0};
        qm_next = {qm[ND-1:0], 1'b1};
        if (is_pos) begin
            q_next  = {q[ND-1:0], 1'b1};
            qm_next = {q[ND-1:0], 1'b0};
        end else if (is_neg) begin
            q_next  = {qm[ND-1:0], 1'b1};
            qm_next = {qm[ND-1:0], 1'b0};
        end
    end

    // NOTE: all state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_ACC;
            q         <= '0;
            qm        <= '1;
            cnt       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                ST_ACC: begin
                    if (accept) begin
                        q  <= q_next;
                        qm <= qm_next;
                        if (cnt == LAST) begin
                            // Last digit: capture the finished Q directly so the
                            // result appears one cycle after the final digit.
                            cnt       <= '0;
                            state     <= ST_OUT;
                            out_valid <= 1'b1;
                            out_data  <= q_next;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                ST_OUT: begin
                    // out_data is left untouched here, so it cannot move under backpressure.
                    if (out_ready) begin
                        state     <= ST_ACC;
                        out_valid <= 1'b0;
                        q         <= '0;
                        qm        <= '1;
                        cnt       <= '0;
                    end
                end
                default: state <= ST_ACC;
            endcase
        end
    end

endmodule

// File: tb/tb_sd_otf_conv.sv
// -----------------------------------------------------------------------------
// tb_sd_otf_conv
// Self-checking bench for sd_otf_conv (ND=8). Expected words are pushed to a
// scoreboard when their last digit is accepted and compared whenever the DUT
// presents out_valid.
// -----------------------------------------------------------------------------
module tb_sd_otf_conv;

    localparam int ND = 8;

    typedef logic [1:0] word_t [ND];

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    in_digit;
    logic          out_valid;
    logic          out_ready;
    logic [ND:0]   out_data;

    int            total = 0;
    int            bad = 0;
    logic [ND:0]   sb[$];
    int            ready_mode = 0;   // 0: ready high, 1: ready low, 2: random
    int            results = 0;
    int            expected_results = 0;

    always #5 clk = ~clk;

    sd_otf_conv #(.ND(ND)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_digit  (in_digit),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    task automatic check(input string tag, input logic [ND:0] obs, input logic [ND:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: plain weighted sum of the digit values.
    function automatic logic [ND:0] ref_val(input word_t w);
        int s = 0;
        for (int i = 0; i < ND; i++) begin
            case (w[i])
                2'b10:   s += (1 << (ND - 1 - i));
                2'b01:   s -= (1 << (ND - 1 - i));
                default: s += 0;
            endcase
        end
        return (ND+1)'(s);
    endfunction

    // Sole driver of out_ready; runs slightly after the main sequence's drive point.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'b0;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Output monitor: every OUT cycle must match the scoreboard head.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            total++;
            assert (sb.size() != 0) else begin
                bad++;
                $error("FAIL spurious_output: got out_data=%h expected no output", out_data);
            end
            if (sb.size() != 0) begin
                check("out_data", out_data, sb[0]);
                check("in_ready_low_in_out", {{ND{1'b0}}, in_ready}, '0);
                if (out_ready) begin
                    void'(sb.pop_front());
                    results++;
                end
            end
        end
    end

    task automatic send_digit(input logic [1:0] d, input int gap);
        int n = 0;
        repeat (gap) begin
            in_valid = 1'b0;
            in_digit = 2'($urandom);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_digit = d;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 100) begin
                check_int("in_ready_wait", int'(in_ready), 1);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_word(input word_t w, input int max_gap, input bit chk_lat);
        for (int i = 0; i < ND; i++)
            send_digit(w[i], (max_gap > 0) ? $urandom_range(0, max_gap) : 0);
        sb.push_back(ref_val(w));
        expected_results++;
        if (chk_lat) begin
            @(negedge clk);
            check("latency_out_valid", {{ND{1'b0}}, out_valid}, 1);
        end
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_int("drain_queue_empty", sb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        word_t w;
        int    r0;

        rst      = 1'b1;
        in_valid = 1'b0;
        in_digit = 2'b00;

        // Reset state
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check("rst_in_ready", {{ND{1'b0}}, in_ready}, 0);
        check("rst_out_valid", {{ND{1'b0}}, out_valid}, 0);
        check("rst_out_data", out_data, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("in_ready_after_rst", {{ND{1'b0}}, in_ready}, 1);
        @(posedge clk);
        #1;

        // Directed words
        w = '{2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
        send_word(w, 0, 1'b1);
        check("ref_plus_msb", ref_val(w), 9'h080);
        drain();
        w = '{2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
        send_word(w, 0, 1'b1);
        drain();
        w = '{default: 2'b01};
        send_word(w, 0, 1'b1);
        drain();
        w = '{default: 2'b10};
        send_word(w, 0, 1'b1);
        drain();
        w = '{2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01};
        send_word(w, 0, 1'b1);
        drain();
        w = '{2'b10, 2'b11, 2'b10, 2'b11, 2'b10, 2'b11, 2'b10, 2'b11};
        send_word(w, 0, 1'b1);
        drain();

        // Backpressure: hold out_ready low 5 cycles in OUT
        ready_mode = 1;
        w = '{2'b10, 2'b01, 2'b00, 2'b10, 2'b11, 2'b01, 2'b10, 2'b10};
        send_word(w, 3, 1'b1);
        repeat (5) begin
            @(negedge clk);
            check("bp_out_valid", {{ND{1'b0}}, out_valid}, 1);
        end
        @(posedge clk);
        #1;
        ready_mode = 0;
        @(negedge clk);              // monitor takes the result here
        @(posedge clk);              // handshake edge
        #1;
        @(negedge clk);
        check("next_word_in_ready", {{ND{1'b0}}, in_ready}, 1);
        check("next_word_out_valid", {{ND{1'b0}}, out_valid}, 0);
        check_int("bp_queue_empty", sb.size(), 0);
        @(posedge clk);
        #1;

        // Reset after 4 digits, then a clean word
        r0 = results;
        for (int i = 0; i < 4; i++) send_digit(2'b10, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("midrst_in_ready", {{ND{1'b0}}, in_ready}, 0);
        check("midrst_out_valid", {{ND{1'b0}}, out_valid}, 0);
        check("midrst_out_data", out_data, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        w = '{2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
        send_word(w, 0, 1'b1);
        drain();
        check_int("single_result_after_abort", results - r0, 1);

        // Reset while a result is pending in OUT
        ready_mode = 1;
        w = '{2'b01, 2'b10, 2'b10, 2'b00, 2'b01, 2'b00, 2'b11, 2'b10};
        send_word(w, 0, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        sb.delete();
        expected_results--;
        @(negedge clk);
        check("outrst_out_valid", {{ND{1'b0}}, out_valid}, 0);
        ready_mode = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
        end

        // Random words with input gaps and random backpressure
        ready_mode = 2;
        for (int k = 0; k < 1000; k++) begin
            for (int i = 0; i < ND; i++) w[i] = 2'($urandom);
            send_word(w, 2, 1'b0);
        end
        ready_mode = 0;
        drain();

        check_int("final_queue_empty", sb.size(), 0);
        check_int("result_count", results, expected_results);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sd_otf_conv.md
SD_OTF_CONV -- requirements
Module: sd_otf_conv

Interface
REQ-001 Parameter ND, default 8, is the number of radix-2 signed digits per result word (one multiplier output word).
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  reset; synchronous, active-high.
REQ-004 in_valid  in  1  in_digit carries a valid digit this cycle.
REQ-005 in_ready  out  1  converter accepts a digit this cycle.
REQ-006 in_digit  in  2  borrow-save digit, MSB-first: 2'b10=+1, 2'b01=-1, 2'b00 and 2'b11=0.
REQ-007 out_valid  out  1  out_data holds a completed conversion.
REQ-008 out_ready  in  1  downstream accepts out_data this cycle.
REQ-009 out_data  out  ND+1  two's-complement integer value sum d_i*2^(ND-1-i), i=0 is the first digit.

Function
REQ-010 The block shall convert one ND-digit MSB-first signed-digit stream into two's complement by on-the-fly conversion, with no carry-propagate adder.
REQ-011 A digit is accepted only in a cycle with in_valid=1 and in_ready=1; in_valid=0 cycles leave all state unchanged.
REQ-012 The block shall hold registers Q and QM (ND+1 bits each), initialised per word to Q=0 and QM=all ones (-1).
REQ-013 On each accepted digit d: d=+1 -> Q={Q,1}, QM={Q,0}; d=0 -> Q={Q,0}, QM={QM,1}; d=-1 -> Q={QM,1}, QM={QM,0}; {X,b} means left-shift by one and append b, keeping the low ND+1 bits.
REQ-014 A digit counter 0..ND-1 shall count accepted digits and wrap to 0 on the ND-th digit.
REQ-015 FSM states: ACC (in_ready=1, out_valid=0) and OUT (in_ready=0, out_valid=1).
REQ-016 ACC->OUT shall occur on acceptance of the ND-th digit; out_data shall equal the final Q from the next cycle (latency 1 cycle after the last digit).
REQ-017 OUT->ACC shall occur on out_valid and out_ready; in the same edge Q, QM and the counter shall be re-initialised, and in_ready shall assert in the following cycle.
REQ-018 In OUT, out_data shall stay stable while out_ready=0 (backpressure); incoming digits are not accepted.
REQ-019 out_data shall be a registered copy of Q; it shall never change while out_valid=1.
REQ-020 Result range is -(2^ND-1)..+(2^ND-1); ND+1 bits shall always suffice and no overflow indication is required.

Reset
REQ-021 While rst=1: state=ACC, Q=0, QM=all ones, counter=0, out_data=0, out_valid=0, in_ready=0.
REQ-022 in_ready shall assert the first cycle after rst deasserts.
REQ-023 rst asserted mid-word or in OUT shall discard the partial word or pending result; no output shall be produced for it.
REQ-024 rst shall take priority over any simultaneous handshake.

Structure
REQ-025 The digit encodings (PLUS=2'b10, MINUS=2'b01, zero codes) and the FSM state encoding shall be defined in a shared package used by the multiplier stages and this block.
REQ-026 One sub-module, sd_digit_decode, shall map in_digit to {is_pos, is_neg}; the Q/QM update shall use only those two signals.
REQ-027 Target size is 120-400 lines of RTL; no latches; all outputs registered except in_ready, which is decoded from state and rst.

Verification
REQ-028 ND=8, digits +1,0,0,0,0,0,0,0 with out_ready=1 -> out_valid one cycle after the last digit, out_data=9'h080 (128).
REQ-029 ND=8, digits -1,0,0,0,0,0,0,0 -> out_data=9'h180 (-128); all eight digits -1 -> 9'h101 (-255).
REQ-030 ND=8, alternating +1,-1,+1,-1,+1,-1,+1,-1 -> 9'h055 (85); the same stream using 2'b11 in place of each -1 digit -> 9'h0AA (170), confirming 2'b11 decodes as 0.
REQ-031 Random in_valid gaps plus out_ready held low 5 cycles -> out_data stable, in_ready=0 throughout OUT; next word starts one cycle after the handshake.
REQ-032 rst pulsed after 4 digits, then a full word +1,+1,0,0,0,0,0,0 is sent -> single result 9'h0C0 (192) and no output for the aborted word.
REQ-033 1000 random words checked against a reference model of sum d_i*2^(7-i).
